// File: rtl/cti8_intc_pkg.sv
// Shared definitions for the CTI-8 interrupt controller: register map,
// channel limit, "no vector" code and the fixed-priority encoder.
package cti8_intc_pkg;

  localparam int unsigned MAX_IRQ  = 8;
  localparam logic [7:0]  VEC_NONE = 8'hFF;

  typedef enum logic [2:0] {
    INTC_PEND = 3'd0,
    INTC_MASK = 3'd1,
    INTC_MODE = 3'd2,
    INTC_NSEL = 3'd3,
    INTC_VEC  = 3'd4
  } intc_reg_e;

  // Lowest-numbered set bit wins; VEC_NONE when nothing is set.
  // Scans from the top down so the last hit is the lowest index.
  function automatic logic [7:0] prio_enc(input logic [MAX_IRQ-1:0] act);
    logic [7:0] v;
    v = VEC_NONE;
    for (int unsigned i = MAX_IRQ; i > 0; i--) begin
      if (act[i-1]) v = 8'(i - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/cti8_sync.sv
// Per-bit multi-stage synchroniser for asynchronous inputs, async reset to 0.
module cti8_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the raw input through STAGES flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/cti8_intc.sv
// CTI-8 interrupt controller: up to 8 edge/level channels, each maskable and
// routable to IRQ or NMI, with a priority vector register that acknowledges
// edge channels when read.
module cti8_intc
  import cti8_intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               cs,
  input  logic [2:0]         addr,
  input  logic               wr,
  input  logic               rd,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  input  logic [NUM_IRQ-1:0] src,
  output logic               irq,
  output logic               nmi
);

  logic [NUM_IRQ-1:0] src_s, src_prev, edge_det;
  logic [NUM_IRQ-1:0] pend, mask, mode, nsel;
  logic [NUM_IRQ-1:0] w1c, ack, active, pend_nxt;
  logic [MAX_IRQ-1:0] act_irq_ext, ack_ext;
  logic [7:0]         vec;
  logic               wr_en, rd_en;

  cti8_sync #(
    .WIDTH  (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (src),
    .q   (src_s)
  );

  assign wr_en = clk_en & cs & wr;
  assign rd_en = clk_en & cs & rd & ~wr;

  // Active set, IRQ vector, and the clear strobes derived from bus accesses
  always_comb begin
    active      = pend & mask;
    act_irq_ext = '0;
    act_irq_ext[NUM_IRQ-1:0] = active & ~nsel;
    vec         = prio_enc(act_irq_ext);
    ack_ext     = '0;
    if (rd_en && addr == INTC_VEC && vec != VEC_NONE) ack_ext[vec[2:0]] = 1'b1;
    ack         = ack_ext[NUM_IRQ-1:0];
    w1c         = (wr_en && addr == INTC_PEND) ? wdata[NUM_IRQ-1:0] : '0;
    edge_det    = src_s & ~src_prev;
    // Edge channels: set beats clear. Level channels: follow the input.
    pend_nxt    = (mode & (edge_det | (pend & ~(w1c | ack)))) | (~mode & src_s);
  end

  // Edge history, pending state and registered interrupt outputs run every clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev <= '0;
      pend     <= '0;
      irq      <= 1'b0;
      nmi      <= 1'b0;
    end else begin
      src_prev <= src_s;
      pend     <= pend_nxt;
      irq      <= |(active & ~nsel);
      nmi      <= |(active & nsel);
    end
  end

  // Configuration registers, written only on qualified bus cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      mode <= '1;
      nsel <= '0;
    end else if (wr_en) begin
      case (addr)
        INTC_MASK: mask <= wdata[NUM_IRQ-1:0];
        INTC_MODE: mode <= wdata[NUM_IRQ-1:0];
        INTC_NSEL: nsel <= wdata[NUM_IRQ-1:0];
        default:   ;
      endcase
    end
  end

  // Combinational read mux; unused channel bits read as 0
  always_comb begin
    rdata = '0;
    case (addr)
      INTC_PEND: rdata[NUM_IRQ-1:0] = pend;
      INTC_MASK: rdata[NUM_IRQ-1:0] = mask;
      INTC_MODE: rdata[NUM_IRQ-1:0] = mode;
      INTC_NSEL: rdata[NUM_IRQ-1:0] = nsel;
      INTC_VEC:  rdata = vec;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: doc/cti8_intc.md
# cti8_intc

Parametrised interrupt controller for the CTI-8 system bus, placed between on-board interrupt sources and the processor's `irq`/`nmi` inputs. It replaces the single hard-wired IRQ/NMI lines with up to 8 maskable channels. Each channel is either edge- or level-sensitive and can be routed to IRQ or NMI. Pending, mask, mode, routing and a priority-encoded vector are exposed as memory-mapped registers on the processor data bus.

## Interface
- `NUM_IRQ`, 8: number of channels, 1..8; unused register bits read 0.
- `SYNC_STAGES`, 2: synchroniser depth for `src`, 2..3.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high, clears all state.
- `clk_en`  in  1  bus qualifier; register accesses take effect only when high.
- `cs`  in  1  chip select from the address decoder.
- `addr`  in  3  register offset.
- `wr`  in  1  write strobe (processor `wr`).
- `rd`  in  1  read strobe; one-cycle pulse per processor read of this block.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data, combinational from `addr`.
- `src`  in  NUM_IRQ  asynchronous interrupt sources, active-high.
- `irq`  out  1  registered, to processor `irq`.
- `nmi`  out  1  registered, to processor `nmi`.

## Operation
- Registers at the following offsets:
  - 0 PEND: read; write-1-to-clear, edge channels only.
  - 1 MASK: R/W, 1 = enabled.
  - 2 MODE: R/W, 1 = edge, 0 = level.
  - 3 NSEL: R/W, 1 = route to NMI.
  - 4 VEC: read only.
  - 5–7: read $00, writes ignored.
- Write occurs on the clock edge when `clk_en & cs & wr`. Read side effects occur when `clk_en & cs & rd & ~wr`.
- Edge channel: a synchronised 0→1 transition sets PEND[n]. The bit stays set until W1C or a VEC acknowledge.
- Level channel: PEND[n] follows the synchronised level every cycle. W1C and acknowledge have no effect.
- Active set is PEND & MASK.
  - `irq` next = |(active & ~NSEL).
  - `nmi` next = |(active & NSEL).
- VEC returns the lowest-numbered channel in active & ~NSEL, or $FF if there is none.
- Reading VEC acknowledges: if the returned channel is edge mode, its PEND bit clears on that edge.
- Priority is fixed: channel 0 is highest.
- Simultaneous set and clear (W1C or acknowledge) on the same bit in the same cycle: **set wins**, and the bit stays 1.
- A MODE change from level to edge keeps the current PEND value. A change from edge to level overwrites PEND with the level on the next cycle.
- The synchroniser and edge detector run every `clk` regardless of `clk_en`, so no edge is lost while `clk_en` is low.

## Timing
- Reset values:
  - PEND = 0, MASK = 0, NSEL = 0.
  - MODE = all ones (edge).
  - Synchroniser and edge-history flops = 0.
  - `irq` = 0, `nmi` = 0.
  - `rdata` reflects the reset registers.
- A source already high at reset release is seen as one edge and sets PEND. Because MASK = 0, no interrupt is raised.
- Latency with SYNC_STAGES = 2, counting from a `src` rise sampled at edge k:
  - PEND set at edge k+2.
  - `irq`/`nmi` high at edge k+3.
- Clear latency: after a W1C, VEC acknowledge or MASK write at edge m, `irq`/`nmi` reflect the change at edge m+1.
- `rdata` is valid in the same cycle as `addr`/`cs`. VEC reads the pre-acknowledge state.
- Reset asserted mid-access aborts the access with no register change. Outputs go to 0 asynchronously.

## Structure
- `cti8_intc_pkg` holds:
  - offsets `INTC_PEND`, `INTC_MASK`, `INTC_MODE`, `INTC_NSEL`, `INTC_VEC`;
  - `VEC_NONE = 8'hFF`;
  - `MAX_IRQ = 8`.
- One sub-module, `cti8_sync`: a parametrised SYNC_STAGES-deep, per-bit synchroniser with asynchronous reset, instantiated NUM_IRQ wide.
- The priority encoder is a function in the package.

## Test plan
- Reset with `src` = $00, then read all offsets: PEND = $00, MASK = $00, MODE = $FF, NSEL = $00, VEC = $FF, `irq` = `nmi` = 0.
- MASK = $FF, pulse `src`[3] for 1 cycle: `irq` rises 3 cycles after the sample edge. VEC returns $03. `irq` falls 1 cycle after the VEC read, and PEND = $00.
- Pulse `src`[5] and `src`[2] together: VEC = $02. After the acknowledge, VEC = $05. After the second acknowledge, VEC = $FF and `irq` = 0.
- MODE = $FE, hold `src`[0] high: W1C $01 leaves PEND[0] = 1 and `irq` stays 1. Dropping `src`[0] clears PEND[0] 2 cycles later.
- NSEL = $80, MASK = $80, pulse `src`[7]: `nmi` = 1, `irq` = 0, VEC = $FF. W1C $80 drops `nmi`.
- A `src`[1] edge landing in the same cycle as W1C $02 leaves PEND[1] = 1. With `clk_en` held low for 10 cycles, a pulse on `src`[4] still sets PEND[4].
